// File: rtl/aes_pkg.sv
// Shared AES definitions: state/byte widths, SubBytes engine FSM states and the
// GF(2^8) arithmetic that generates the forward and inverse S-box values.
package aes_pkg;

    localparam int unsigned STATE_W = 128;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned NBYTES  = STATE_W / BYTE_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } aes_state_e;

    // Multiply by x modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
    function automatic logic [BYTE_W-1:0] gf_xtime(input logic [BYTE_W-1:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [BYTE_W-1:0] gf_mul(input logic [BYTE_W-1:0] a,
                                                 input logic [BYTE_W-1:0] b);
        logic [BYTE_W-1:0] aa;
        logic [BYTE_W-1:0] bb;
        logic [BYTE_W-1:0] p;
        aa = a;
        bb = b;
        p  = '0;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p ^= aa;
            aa = gf_xtime(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse, and maps 0 to 0 as AES requires.
    function automatic logic [BYTE_W-1:0] gf_inv(input logic [BYTE_W-1:0] a);
        logic [BYTE_W-1:0] sq;
        logic [BYTE_W-1:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [BYTE_W-1:0] sbox_fwd(input logic [BYTE_W-1:0] x);
        logic [BYTE_W-1:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [BYTE_W-1:0] sbox_inv(input logic [BYTE_W-1:0] y);
        logic [BYTE_W-1:0] s;
        s = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
        return gf_inv(s);
    endfunction

endpackage

// File: rtl/aes_sbox_byte.sv
// Single-byte AES S-box lane. The inverse path exists only when
// SUB_BYTES_INV_EN is defined; otherwise i_inv is ignored.
module aes_sbox_byte
    import aes_pkg::*;
(
    input  logic [BYTE_W-1:0] i_byte,
    input  logic              i_inv,
    output logic [BYTE_W-1:0] o_byte_c
);

`ifdef SUB_BYTES_INV_EN
    assign o_byte_c = i_inv ? sbox_inv(i_byte) : sbox_fwd(i_byte);
`else
    logic w_unused_inv;
    assign w_unused_inv = i_inv;
    assign o_byte_c     = sbox_fwd(i_byte);
`endif

endmodule

// File: rtl/sub_bytes_folded.sv
// Folded AES SubBytes engine: LANES S-boxes sweep the 16 state bytes in place
// over 16/LANES cycles. Define SUB_BYTES_INV_EN to build the inverse S-box.
module sub_bytes_folded
    import aes_pkg::*;
#(
    parameter int unsigned LANES = 4
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_data,
    input  logic               in_inv,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_data,
    output logic               busy
);

    localparam int unsigned NCHUNK = NBYTES / LANES;
    localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned IDX_W  = $clog2(STATE_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sub_bytes_folded: LANES must be 1, 2, 4, 8 or 16");
    end

    aes_state_e         r_state, w_state_nxt;
    logic [STATE_W-1:0] r_work, w_work_nxt, w_work_upd;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_out_valid, w_out_valid_nxt;
    logic               w_mode;
    logic               w_accept;
    logic [LANES-1:0][BYTE_W-1:0] w_lane_in;
    logic [LANES-1:0][BYTE_W-1:0] w_lane_out;

`ifdef SUB_BYTES_INV_EN
    logic r_inv, w_inv_nxt;
    assign w_mode = r_inv;
`else
    logic w_unused_inv;
    assign w_unused_inv = in_inv;
    assign w_mode       = 1'b0;
`endif

    // MSB position of the byte handled by lane l while the counter is c.
    function automatic logic [IDX_W-1:0] lane_msb(input logic [CNT_W-1:0] c,
                                                  input int unsigned l);
        return IDX_W'(STATE_W - 1 - BYTE_W * (LANES * 32'(c) + l));
    endfunction

    assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_work;
    assign busy      = (r_state == BUSY);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        aes_sbox_byte u_sbox (
            .i_byte   (w_lane_in[l]),
            .i_inv    (w_mode),
            .o_byte_c (w_lane_out[l])
        );
    end

    // Gather the current chunk into the lanes.
    always_comb begin
        w_lane_in = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            w_lane_in[LANE_W'(l)] = r_work[lane_msb(r_cnt, l) -: BYTE_W];
        end
    end

    // Scatter the substituted chunk back into its original byte positions.
    always_comb begin
        w_work_upd = r_work;
        for (int unsigned l = 0; l < LANES; l++) begin
            w_work_upd[lane_msb(r_cnt, l) -: BYTE_W] = w_lane_out[LANE_W'(l)];
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_work_nxt      = r_work;
        w_cnt_nxt       = r_cnt;
        w_out_valid_nxt = r_out_valid;
`ifdef SUB_BYTES_INV_EN
        w_inv_nxt       = r_inv;
`endif
        case (r_state)
            IDLE, DONE: begin
                if (w_accept) begin
                    w_state_nxt     = BUSY;
                    w_work_nxt      = in_data;
                    w_cnt_nxt       = '0;
                    w_out_valid_nxt = 1'b0;
`ifdef SUB_BYTES_INV_EN
                    w_inv_nxt       = in_inv;
`endif
                end else if (r_state == DONE && out_ready) begin
                    w_state_nxt     = IDLE;
                    w_out_valid_nxt = 1'b0;
                end
            end
            BUSY: begin
                w_work_nxt = w_work_upd;
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt     = DONE;
                    w_out_valid_nxt = 1'b1;
                    w_cnt_nxt       = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_out_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_work      <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
`ifdef SUB_BYTES_INV_EN
            r_inv       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_work      <= w_work_nxt;
            r_cnt       <= w_cnt_nxt;
            r_out_valid <= w_out_valid_nxt;
`ifdef SUB_BYTES_INV_EN
            r_inv       <= w_inv_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_sub_bytes_folded.sv
// Self-checking bench for sub_bytes_folded: a LANES=4 instance plus a width
// sweep (1, 2, 8, 16), checked against a table-driven GF(2^8) reference model.
`timescale 1ns/1ps
module tb_sub_bytes_folded;

    localparam int unsigned MAIN_LANES  = 4;
    localparam int unsigned MAIN_NCHUNK = 16 / MAIN_LANES;
    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
`ifdef SUB_BYTES_INV_EN
    localparam bit INV_BUILT = 1'b1;
`else
    localparam bit INV_BUILT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_inv = 1'b0;
    logic [127:0] in_data = '0;
    logic         out_ready = 1'b0;
    logic         in_ready, out_valid, busy;
    logic [127:0] out_data;

    logic [3:0]   sw_ready, sw_valid, sw_busy;
    logic [127:0] sw_data [4];

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ref_fwd [256];
    logic [7:0] ref_inv [256];

    always #5 clk = ~clk;

    sub_bytes_folded #(.LANES(MAIN_LANES)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        sub_bytes_folded #(.LANES((g < 2) ? (1 << g) : (1 << (g + 1)))) u_sw (
            .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(sw_ready[g]),
            .in_data(in_data), .in_inv(in_inv), .out_valid(sw_valid[g]),
            .out_ready(out_ready), .out_data(sw_data[g]), .busy(sw_busy[g])
        );
    end

    // Polynomial product reduced modulo 0x11b.
    function automatic logic [7:0] ref_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p ^= (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p ^= (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_model();
        logic [7:0] x, iv, b, c;
        c = 8'h63;
        for (int a = 0; a < 256; a++) begin
            x  = 8'(a);
            iv = 8'h00;
            for (int y = 1; y < 256; y++) if (ref_gmul(x, 8'(y)) == 8'h01) iv = 8'(y);
            for (int i = 0; i < 8; i++)
                b[i] = iv[i] ^ iv[(i+4)%8] ^ iv[(i+5)%8] ^ iv[(i+6)%8] ^ iv[(i+7)%8] ^ c[i];
            ref_fwd[a] = b;
            ref_inv[b] = x;
        end
    endtask

    function automatic logic [127:0] ref_block(input logic [127:0] d, input logic inv);
        logic [127:0] o;
        logic [7:0]   b;
        for (int k = 0; k < 16; k++) begin
            b = d[127 - 8*k -: 8];
            o[127 - 8*k -: 8] = (INV_BUILT && inv) ? ref_inv[b] : ref_fwd[b];
        end
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
    endtask

    // Offer one block, wait for accept, then count cycles to out_valid.
    task automatic run_block(input logic [127:0] d, input logic inv, output int lat,
                             output logic [127:0] res, output bit rdy_low);
        int guard;
        in_data  = d;
        in_inv   = inv;
        in_valid = 1'b1;
        #1;
        guard = 0;
        while (!in_ready && guard < 40) begin
            step();
            guard++;
        end
        step();
        in_valid = 1'b0;
        in_inv   = ~inv;
        in_data  = ~d;
        lat      = 0;
        rdy_low  = 1'b1;
        while (!out_valid && lat < 40) begin
            if (busy && in_ready) rdy_low = 1'b0;
            step();
            lat++;
        end
        res = out_data;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_data !== 128'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", out_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
        step();
    endtask

    task automatic test_fips_fwd();
        int lat; logic [127:0] res; bit ok;
        out_ready = 1'b1;
        run_block(FIPS_IN, 1'b0, lat, res, ok);
        n_checks++; if (lat != MAIN_NCHUNK) begin n_fail++; $display("FAIL fips_latency: got %0d expected %0d", lat, MAIN_NCHUNK); end
        n_checks++; if (res !== FIPS_OUT) begin n_fail++; $display("FAIL fips_data: got %h expected %h", res, FIPS_OUT); end
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL fips_ready_busy: in_ready high during BUSY"); end
        step();
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL fips_drain: valid=%b ready=%b expected 0/1", out_valid, in_ready); end
    endtask

    task automatic test_inverse();
        int lat; logic [127:0] res, exp1, exp2; bit ok;
        out_ready = 1'b1;
`ifdef SUB_BYTES_INV_EN
        run_block(FIPS_OUT, 1'b1, lat, res, ok);
        exp1 = FIPS_IN;
`else
        run_block(FIPS_IN, 1'b1, lat, res, ok);
        exp1 = FIPS_OUT;
`endif
        n_checks++; if (res !== exp1) begin n_fail++; $display("FAIL inv_vector: got %h expected %h", res, exp1); end
        step();
        exp2 = INV_BUILT ? 128'h0 : {16{8'hfb}};
        run_block({16{8'h63}}, 1'b1, lat, res, ok);
        n_checks++; if (res !== exp2) begin n_fail++; $display("FAIL inv_all63: got %h expected %h", res, exp2); end
        step();
    endtask

    task automatic test_corners();
        int lat; logic [127:0] d, res, e; bit ok;
        d = rand128();
        d[127:104] = 24'h0053ff;
        e = ref_block(d, 1'b0);
        out_ready = 1'b1;
        run_block(d, 1'b0, lat, res, ok);
        n_checks++; if (res[127:120] !== 8'h63) begin n_fail++; $display("FAIL corner_00: got %h expected 63", res[127:120]); end
        n_checks++; if (res[119:112] !== 8'hed) begin n_fail++; $display("FAIL corner_53: got %h expected ed", res[119:112]); end
        n_checks++; if (res[111:104] !== 8'h16) begin n_fail++; $display("FAIL corner_ff: got %h expected 16", res[111:104]); end
        n_checks++; if (res !== e) begin n_fail++; $display("FAIL corner_block: got %h expected %h", res, e); end
        step();
    endtask

    task automatic test_random();
        int lat; logic [127:0] d, res, e, held; bit ok; logic inv; int hold;
        for (int n = 0; n < 10; n++) begin
            d    = rand128();
            inv  = 1'($urandom_range(0, 1));
            e    = ref_block(d, inv);
            hold = $urandom_range(0, 3);
            out_ready = (hold == 0);
            run_block(d, inv, lat, res, ok);
            n_checks++; if (res !== e || lat != MAIN_NCHUNK) begin n_fail++; $display("FAIL random_%0d: got %h lat %0d expected %h lat %0d", n, res, lat, e, MAIN_NCHUNK); end
            held = out_data;
            repeat (hold) step();
            n_checks++; if (out_valid !== 1'b1 || out_data !== held) begin n_fail++; $display("FAIL random_hold_%0d: valid=%b data=%h expected 1 %h", n, out_valid, out_data, held); end
            out_ready = 1'b1;
            step();
        end
    endtask

    task automatic test_backpressure();
        int lat; logic [127:0] d1, d2, e1, e2, res; bit ok;
        d1 = rand128(); d2 = rand128();
        e1 = ref_block(d1, 1'b0); e2 = ref_block(d2, 1'b1);
        out_ready = 1'b0;
        run_block(d1, 1'b0, lat, res, ok);
        n_checks++; if (res !== e1) begin n_fail++; $display("FAIL bp_first: got %h expected %h", res, e1); end
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== e1 || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold_%0d: valid=%b ready=%b data=%h expected 1/0 %h", i, out_valid, in_ready, out_data, e1);
            end
        end
        in_data = d2; in_inv = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_rise: got %b expected 1", in_ready); end
        step();
        in_valid = 1'b0; in_inv = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL bp_restart: valid=%b busy=%b expected 0/1", out_valid, busy); end
        for (int i = 1; i < int'(MAIN_NCHUNK); i++) begin
            step();
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_gap_%0d: valid=%b expected 0", i, out_valid); end
        end
        step();
        n_checks++; if (out_valid !== 1'b1 || out_data !== e2) begin n_fail++; $display("FAIL bp_second: valid=%b data=%h expected 1 %h", out_valid, out_data, e2); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [127:0] blk [4]; logic [127:0] exp [4]; logic bi [4];
        int n_sent, n_recv, last; bit acc, hs;
        for (int i = 0; i < 4; i++) begin
            blk[i] = rand128(); bi[i] = 1'($urandom_range(0, 1)); exp[i] = ref_block(blk[i], bi[i]);
        end
        n_sent = 0; n_recv = 0; last = 0;
        out_ready = 1'b1; in_valid = 1'b1; in_data = blk[0]; in_inv = bi[0];
        for (int cyc = 0; cyc < 80 && n_recv < 4; cyc++) begin
            #1;
            acc = in_valid && in_ready;
            hs  = out_valid && out_ready;
            if (hs) begin
                n_checks++; if (out_data !== exp[n_recv]) begin n_fail++; $display("FAIL b2b_data_%0d: got %h expected %h", n_recv, out_data, exp[n_recv]); end
                if (n_recv > 0) begin
                    n_checks++; if (cyc - last != int'(MAIN_NCHUNK) + 1) begin n_fail++; $display("FAIL b2b_period_%0d: got %0d expected %0d", n_recv, cyc - last, MAIN_NCHUNK + 1); end
                end
                last = cyc;
                n_recv++;
            end
            step();
            if (acc) begin
                n_sent++;
                if (n_sent < 4) begin in_data = blk[n_sent]; in_inv = bi[n_sent]; end
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        n_checks++; if (n_recv != 4) begin n_fail++; $display("FAIL b2b_timeout: got %0d results expected 4", n_recv); end
        step();
    endtask

    task automatic test_sweep();
        int exp_lat [4]; int lat [4]; logic [127:0] got [4]; bit seen [4];
        exp_lat = '{16, 8, 2, 1};
        do_reset();
        out_ready = 1'b1; in_data = FIPS_IN; in_inv = 1'b0; in_valid = 1'b1;
        #1;
        n_checks++; if (sw_ready !== 4'hf || in_ready !== 1'b1) begin n_fail++; $display("FAIL sweep_ready: got %b/%b expected 1111/1", sw_ready, in_ready); end
        step();
        in_valid = 1'b0;
        for (int g = 0; g < 4; g++) begin seen[g] = 1'b0; lat[g] = -1; got[g] = '0; end
        for (int k = 1; k <= 20; k++) begin
            step();
            for (int g = 0; g < 4; g++) begin
                if (!seen[g] && sw_valid[g]) begin seen[g] = 1'b1; lat[g] = k; got[g] = sw_data[g]; end
            end
        end
        for (int g = 0; g < 4; g++) begin
            n_checks++; if (lat[g] != exp_lat[g]) begin n_fail++; $display("FAIL sweep_latency_%0d: got %0d expected %0d", g, lat[g], exp_lat[g]); end
            n_checks++; if (got[g] !== FIPS_OUT) begin n_fail++; $display("FAIL sweep_data_%0d: got %h expected %h", g, got[g], FIPS_OUT); end
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [127:0] d, res, e; bit ok, seen;
        out_ready = 1'b1;
        in_data = rand128(); in_inv = 1'b0; in_valid = 1'b1;
        #1;
        step();
        in_valid = 1'b0;
        step(); step();
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 128'h0) begin n_fail++; $display("FAIL midrst_clear: valid=%b busy=%b data=%h expected 0", out_valid, busy, out_data); end
        repeat (2) step();
        rst_n = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: ready=%b busy=%b expected 1/0", in_ready, busy); end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin step(); if (out_valid) seen = 1'b1; end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_stale: out_valid seen after reset"); end
        d = rand128(); e = ref_block(d, 1'b0);
        run_block(d, 1'b0, lat, res, ok);
        n_checks++; if (res !== e || lat != MAIN_NCHUNK) begin n_fail++; $display("FAIL midrst_fresh: got %h lat %0d expected %h lat %0d", res, lat, e, MAIN_NCHUNK); end
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        build_model();
        test_reset();
        test_fips_fwd();
        test_inverse();
        test_corners();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_sweep();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sub_bytes_folded.md
Name: sub_bytes_folded

Overview:
Parametrised, handshaked AES SubBytes engine for the 128-bit state. It time-multiplexes LANES byte S-boxes over the 16 state bytes, trading latency for area, and optionally supports the inverse S-box for decryption. It sits between the round-key/ShiftRows stages of the round datapath, with valid/ready on both sides.

Parameters:
LANES, 4, number of byte S-box instances; legal values 1, 2, 4, 8, 16; other values are an elaboration error.
NCHUNK, 16/LANES (derived, localparam), number of processing cycles per block.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream block valid
in_ready  output  1  engine can accept a block this cycle
in_data  input  128  state; byte 0 = [127:120], byte 15 = [7:0]
in_inv  input  1  1 = inverse S-box, 0 = forward; sampled with in_data
out_valid  output  1  result available
out_ready  input  1  downstream accepts result
out_data  output  128  substituted state, same byte order
busy  output  1  high while in state BUSY

Behaviour:
- Clock is clk. Reset is rst_n: asynchronous assert, active-low. On reset: state=IDLE, out_valid=0, out_data=0, chunk counter=0, latched mode=0, busy=0. in_ready=1 once reset is released.
- FSM states: IDLE, BUSY, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is combinational, with no dependence on in_valid.
- Accept occurs when in_valid && in_ready at an edge. On accept: the work register loads in_data, the mode register loads in_inv, the counter is set to 0, and state goes to BUSY.
- BUSY: in each cycle the bytes [c*LANES .. c*LANES+LANES-1], where c is the counter, pass through the S-boxes and are written back into the work register in place. The counter then increments.
- When c==NCHUNK-1, the write-back also sets state=DONE and out_valid=1.
- Latency: out_valid is high exactly NCHUNK cycles after the accept edge. For LANES=4 this is 4 cycles; for LANES=16 it is 1 cycle.
- DONE: out_data (the work register) and out_valid stay stable until out_valid && out_ready.
  - On that handshake without a simultaneous accept: state goes to IDLE and out_valid goes to 0.
  - If an accept occurs at the same edge: the new block loads and state goes straight to BUSY, so back-to-back blocks complete every NCHUNK+1 cycles.
- in_valid and in_data are ignored while in BUSY. No input is dropped, because in_ready is low then.
- Changing in_inv after accept has no effect on the block in flight.
- Reset asserted mid-block discards the block. No partial result is ever presented.
- Counter width is clog2(NCHUNK), minimum 1 bit, and it wraps to 0 on entry to DONE.

Optional Feature:
SUB_BYTES_INV_EN
- Defined: each lane instantiates both forward and inverse S-box logic, and the latched mode selects between them.
- Undefined: forward S-box only. in_inv is accepted and ignored, the mode register is not built, and the result is always forward SubBytes.

Decomposition:
- Shared package aes_pkg holds:
  - STATE_W=128 and BYTE_W=8;
  - the FSM state enum (IDLE/BUSY/DONE);
  - the forward and inverse S-box constant tables, or functions generating them.
- One sub-module, aes_sbox_byte: 8-bit combinational in/out plus an inv select, with the inverse path present only under SUB_BYTES_INV_EN. It is instantiated LANES times in a generate loop.

Test Plan:
- Reset and idle:
  - Hold rst_n=0 → out_valid=0, out_data=0, busy=0.
  - Release rst_n → in_ready=1.
- FIPS-197 forward vector, LANES=4:
  - Stimulus: in_data=193de3bea0f4e22b9ac68d2ae9f84808, in_inv=0, out_ready=1.
  - Response: out_valid rises 4 cycles after accept with out_data=d42711aee0bf98f1b8b45de51e415230. in_ready stays 0 during BUSY.
- Inverse vector (SUB_BYTES_INV_EN defined):
  - Stimulus: in_data=d42711aee0bf98f1b8b45de51e415230, in_inv=1.
  - Response: out_data=193de3bea0f4e22b9ac68d2ae9f84808.
  - Stimulus: all bytes 0x63 → response: all bytes 0x00.
- Backpressure:
  - Complete a block with out_ready=0 for 10 cycles → out_data stable, out_valid held, in_ready=0.
  - Raise out_ready with in_valid=1 → handshake and new accept on the same edge, and out_valid drops for the next NCHUNK cycles.
- Width sweep:
  - Rerun the FIPS vector with LANES=1, 2, 8, 16 → latency 16, 8, 2, 1 and identical out_data.
  - Check S-box corner points: 0x00→0x63, 0x53→0xED, 0xFF→0x16.
- Reset mid-block:
  - Assert rst_n=0 two cycles after accept → out_valid=0 immediately.
  - After release: state is IDLE and no stale result appears. A fresh block then produces a correct result.
